// File: rtl/sprite_addr_cal_pkg.sv
// Shared field layout for sprite pattern descriptors and sprite state words.
// Also used by the display block's command decoder when it unpacks these words.
package sprite_addr_cal_pkg;

  localparam int ADDR_W  = 16;
  localparam int COORD_W = 10;

  // Box and sprite comparisons need one bit of headroom over ADDR_W.
  localparam int EXT_W   = ADDR_W + 1;

  localparam int PATTERN_INFO_W = 5 * ADDR_W;
  localparam int SPRITE_INFO_W  = 32;

  localparam int PAT_BASE_LSB   = 64;
  localparam int PAT_SPR_W_LSB  = 48;
  localparam int PAT_SPR_H_LSB  = 32;
  localparam int PAT_DRAW_W_LSB = 16;
  localparam int PAT_DRAW_H_LSB = 0;

  localparam int SPR_VIS_BIT  = 31;
  localparam int SPR_FLIP_BIT = 30;
  localparam int SPR_X_HI     = 29;
  localparam int SPR_X_LO     = 20;
  localparam int SPR_Y_HI     = 19;
  localparam int SPR_Y_LO     = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] sprite_w;
    logic [ADDR_W-1:0] sprite_h;
    logic [ADDR_W-1:0] draw_w;
    logic [ADDR_W-1:0] draw_h;
  } pattern_info_t;

  typedef struct packed {
    logic               visible;
    logic               flip;
    logic [COORD_W-1:0] x_pos;
    logic [COORD_W-1:0] y_pos;
    logic [9:0]         reserved;
  } sprite_info_t;

endpackage

// File: rtl/sprite_addr_cal_if.sv
// Raster/sprite inputs and pixel-index outputs of one sprite address calculator.
interface sprite_addr_cal_if;
  import sprite_addr_cal_pkg::*;

  logic [PATTERN_INFO_W-1:0] pattern_info;
  logic [SPRITE_INFO_W-1:0]  sprite_info;
  logic [COORD_W-1:0]        hcount;
  logic [COORD_W-1:0]        vcount;
  logic [ADDR_W-1:0]         addr_output;
  logic                      valid;

  modport master (
    output pattern_info, sprite_info, hcount, vcount,
    input  addr_output, valid
  );

  modport slave (
    input  pattern_info, sprite_info, hcount, vcount,
    output addr_output, valid
  );

endinterface

// File: rtl/sprite_addr_cal.sv
// Per-pixel sprite address generator: maps the raster position onto a linear
// index into the sprite pixel memory, with one cycle of latency.
module sprite_addr_cal
  import sprite_addr_cal_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  sprite_addr_cal_if.slave bus
);

  pattern_info_t     pat;
  sprite_info_t      spr;
  logic [9:0]        unused_reserved;

  logic [EXT_W-1:0]  h_ext;
  logic [EXT_W-1:0]  v_ext;
  logic [EXT_W-1:0]  x_ext;
  logic [EXT_W-1:0]  y_ext;
  logic [EXT_W-1:0]  x_end;
  logic [EXT_W-1:0]  y_end;
  logic [EXT_W-1:0]  dx;
  logic [EXT_W-1:0]  dy;

  logic              in_box;
  logic              in_sprite;
  logic              hit;

  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] prod;
  logic [ADDR_W-1:0] address;

  logic [ADDR_W-1:0] addr_next;
  logic              valid_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              valid_reg;

  assign pat             = pattern_info_t'(bus.pattern_info);
  assign spr             = sprite_info_t'(bus.sprite_info);
  assign unused_reserved = spr.reserved;

  always_comb begin
    h_ext = EXT_W'(bus.hcount);
    v_ext = EXT_W'(bus.vcount);
    x_ext = EXT_W'(spr.x_pos);
    y_ext = EXT_W'(spr.y_pos);

    // Box ends are kept in 17 bits, so a box running past column 1023 is
    // clipped by the raster range rather than wrapping to column 0.
    x_end = x_ext + EXT_W'(pat.draw_w);
    y_end = y_ext + EXT_W'(pat.draw_h);

    dx = h_ext - x_ext;
    dy = v_ext - y_ext;

    in_box    = (h_ext >= x_ext) && (h_ext < x_end) &&
                (v_ext >= y_ext) && (v_ext < y_end);
    in_sprite = (dx < EXT_W'(pat.sprite_w)) && (dy < EXT_W'(pat.sprite_h));
    hit       = spr.visible && in_box && in_sprite;

    col     = spr.flip ? (pat.sprite_w - ADDR_W'(1) - dx[ADDR_W-1:0])
                       : dx[ADDR_W-1:0];
    row     = dy[ADDR_W-1:0];
    prod    = row * pat.sprite_w;
    address = pat.base + prod + col;

    addr_next  = hit ? address : '0;
    valid_next = hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      addr_reg  <= addr_next;
      valid_reg <= valid_next;
    end
  end

  assign bus.addr_output = addr_reg;
  assign bus.valid       = valid_reg;

endmodule

// File: tb/tb_sprite_addr_cal.sv
// Directed and randomized checks of sprite_addr_cal against a plain-integer
// model of the placement, clipping, flip and address rules.
module tb_sprite_addr_cal;
  import sprite_addr_cal_pkg::*;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  sprite_addr_cal_if bus ();

  sprite_addr_cal dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pattern_info_t mk_pat(int base, int sw, int sh, int dw, int dh);
    pattern_info_t p;
    p.base     = 16'(base);
    p.sprite_w = 16'(sw);
    p.sprite_h = 16'(sh);
    p.draw_w   = 16'(dw);
    p.draw_h   = 16'(dh);
    return p;
  endfunction

  function automatic sprite_info_t mk_spr(bit vis, bit flip, int x, int y);
    sprite_info_t s;
    s.visible  = vis;
    s.flip     = flip;
    s.x_pos    = 10'(x);
    s.y_pos    = 10'(y);
    s.reserved = 10'($urandom);
    return s;
  endfunction

  // Reference: integer arithmetic straight from the placement rules.
  function automatic void ref_model(pattern_info_t p, sprite_info_t s, int h, int v,
                                    output logic ev, output logic [15:0] ea);
    int x, y, dx, dy, sw, col;
    bit hit;
    x  = int'(s.x_pos);
    y  = int'(s.y_pos);
    sw = int'(p.sprite_w);
    dx = h - x;
    dy = v - y;
    hit = s.visible && (h >= x) && (h < x + int'(p.draw_w)) &&
          (v >= y) && (v < y + int'(p.draw_h)) &&
          (dx < sw) && (dy < int'(p.sprite_h));
    ev = hit;
    ea = 16'd0;
    if (hit) begin
      col = s.flip ? (sw - 1 - dx) : dx;
      ea  = 16'((int'(p.base) + dy * sw + col) & 32'hFFFF);
    end
  endfunction

  task automatic check(string tag, logic exp_valid, logic [15:0] exp_addr);
    tests++;
    assert (bus.valid === exp_valid) else begin
      fails++;
      $error("FAIL %s valid: observed=%b expected=%b", tag, bus.valid, exp_valid);
    end
    tests++;
    assert (bus.addr_output === exp_addr) else begin
      fails++;
      $error("FAIL %s addr: observed=%0d expected=%0d", tag, bus.addr_output, exp_addr);
    end
    $display("[TB] %-14s h=%0d v=%0d -> valid=%b addr=%0d (exp %b/%0d)",
             tag, bus.hcount, bus.vcount, bus.valid, bus.addr_output, exp_valid, exp_addr);
  endtask

  task automatic drive(pattern_info_t p, sprite_info_t s, int h, int v);
    bus.pattern_info = p;
    bus.sprite_info  = s;
    bus.hcount       = 10'(h);
    bus.vcount       = 10'(v);
  endtask

  task automatic step(string tag, pattern_info_t p, sprite_info_t s, int h, int v,
                      logic exp_valid, logic [15:0] exp_addr);
    @(negedge clk);
    drive(p, s, h, v);
    @(posedge clk);
    #1;
    check(tag, exp_valid, exp_addr);
  endtask

  initial begin
    pattern_info_t p16, ptall, pr;
    sprite_info_t  s_n, s_f, s_t, s_hid, sr;
    logic          ev;
    logic [15:0]   ea;
    int            x, y, h, v;

    tests = 0;
    fails = 0;
    p16   = mk_pat(0, 16, 16, 16, 16);
    ptall = mk_pat(1792, 16, 32, 16, 32);
    s_n   = mk_spr(1'b1, 1'b0, 100, 50);
    s_f   = mk_spr(1'b1, 1'b1, 100, 50);
    s_t   = mk_spr(1'b1, 1'b0, 200, 10);
    s_hid = mk_spr(1'b0, 1'b0, 100, 50);

    // Reset held with a hitting raster: outputs must stay zero across edges.
    reset = 1'b0;
    drive(p16, s_n, 105, 55);
    #1;
    check("reset_init", 1'b0, 16'd0);
    @(posedge clk);
    #1;
    check("reset_held", 1'b0, 16'd0);
    @(negedge clk);
    reset = 1'b1;

    step("origin",      p16, s_n, 100, 50, 1'b1, 16'd0);
    step("far_corner",  p16, s_n, 115, 65, 1'b1, 16'd255);
    step("right_edge",  p16, s_n, 116, 50, 1'b0, 16'd0);
    step("bottom_edge", p16, s_n, 100, 66, 1'b0, 16'd0);
    step("left_edge",   p16, s_n,  99, 50, 1'b0, 16'd0);
    step("top_edge",    p16, s_n, 100, 49, 1'b0, 16'd0);
    step("flip_origin", p16, s_f, 100, 50, 1'b1, 16'd15);
    step("flip_row1",   p16, s_f, 115, 51, 1'b1, 16'd16);
    step("tall_mid",    ptall, s_t, 203, 20, 1'b1, 16'd1955);
    step("tall_last",   ptall, s_t, 215, 41, 1'b1, 16'd2303);
    step("tall_below",  ptall, s_t, 215, 42, 1'b0, 16'd0);
    step("draw_gt_spr", mk_pat(0, 8, 8, 16, 16), s_n, 108, 50, 1'b0, 16'd0);
    step("zero_sw",     mk_pat(0, 0, 16, 16, 16), s_n, 100, 50, 1'b0, 16'd0);
    step("zero_dh",     mk_pat(0, 16, 16, 16, 0), s_n, 100, 50, 1'b0, 16'd0);
    step("clip_right",  mk_pat(0, 64, 4, 64, 4), mk_spr(1'b1, 1'b0, 1000, 0), 5, 0, 1'b0, 16'd0);
    step("clip_inside", mk_pat(0, 64, 4, 64, 4), mk_spr(1'b1, 1'b0, 1000, 0), 1023, 1, 1'b1, 16'd87);
    step("addr_wrap",   mk_pat(65530, 16, 16, 16, 16), s_n, 110, 50, 1'b1, 16'd4);
    step("hidden",      p16, s_hid, 105, 55, 1'b0, 16'd0);

    // Visibility change must show exactly one edge later.
    @(negedge clk);
    drive(p16, s_n, 105, 55);
    #1;
    check("vis_before", 1'b0, 16'd0);
    @(posedge clk);
    #1;
    check("vis_after", 1'b1, 16'd85);

    // Asynchronous reset in the middle of a hit.
    #2;
    reset = 1'b0;
    #1;
    check("async_rst", 1'b0, 16'd0);
    @(posedge clk);
    #1;
    check("rst_hold", 1'b0, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release", 1'b1, 16'd85);

    // Randomized placements clustered around the box so hits and misses mix.
    for (int i = 0; i < 300; i++) begin
      pr = mk_pat(int'($urandom_range(0, 65535)), int'($urandom_range(0, 40)),
                  int'($urandom_range(0, 40)), int'($urandom_range(0, 48)),
                  int'($urandom_range(0, 48)));
      x  = int'($urandom_range(0, 1023));
      y  = int'($urandom_range(0, 1023));
      sr = mk_spr(($urandom_range(0, 7) != 0), 1'($urandom), x, y);
      h  = x + int'($urandom_range(0, 56)) - 4;
      v  = y + int'($urandom_range(0, 56)) - 4;
      if (h < 0) h = 0;
      if (h > 1023) h = 1023;
      if (v < 0) v = 0;
      if (v > 1023) v = 1023;
      ref_model(pr, sr, h, v, ev, ea);
      step("random", pr, sr, h, v, ev, ea);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
